// File: rtl/ctrl_pkg.sv
// Shared widths, control-word bit map and bubble constant for the control pipeline.
package ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned CTRL_W = 13;
  localparam int unsigned CNT_W  = 16;

  localparam int unsigned B_REGDST   = 3;
  localparam int unsigned B_REGWR    = 4;
  localparam int unsigned B_BGTZ     = 5;
  localparam int unsigned B_BNE      = 6;
  localparam int unsigned B_BEQ      = 7;
  localparam int unsigned B_ALUSRC   = 8;
  localparam int unsigned B_MEMWR    = 9;
  localparam int unsigned B_MEMRD    = 10;
  localparam int unsigned B_MEMTOREG = 11;
  localparam int unsigned B_EXTOP    = 12;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  // rt is a source operand for R-type, stores and compare branches.
  function automatic logic reads_rt(input logic [CTRL_W-1:0] c);
    return c[B_REGDST] | c[B_MEMWR] | c[B_BEQ] | c[B_BNE];
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection between the load in EX and the instruction in ID.
module hazard_detect
  import ctrl_pkg::*;
(
  input  logic [CTRL_W-1:0] ex_ctrl_i,
  input  logic [REG_W-1:0]  ex_dest_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [REG_W-1:0]  id_rs_i,
  input  logic [REG_W-1:0]  id_rt_i,
  output logic              hazard_o
);

  logic dest_nz;
  logic rs_match;
  logic rt_match;
  logic unused_ctrl_bits;

  assign unused_ctrl_bits = ^{ex_ctrl_i, id_ctrl_i};

  // $zero is never a real producer, so it can never cause a stall.
  assign dest_nz  = (ex_dest_i != REG_W'(0));
  assign rs_match = (ex_dest_i == id_rs_i);
  assign rt_match = (ex_dest_i == id_rt_i) & reads_rt(id_ctrl_i);

  assign hazard_o = ex_ctrl_i[B_MEMRD] & dest_nz & (rs_match | rt_match);

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline ID/EX -> EX/MEM -> MEM/WB with branch resolution in EX and load-use stall.
// Optional stall/flush event counters are enabled by defining CTRL_PIPE_CNT_EN.
module ctrl_pipe
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              ex_zero,
  input  logic              ex_neg,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [REG_W-1:0]  ex_dest,
  output logic [REG_W-1:0]  mem_dest,
  output logic [REG_W-1:0]  wb_dest,
  output logic              stall,
  output logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [CTRL_W-1:0] mem_ctrl_q, wb_ctrl_q;
  logic [REG_W-1:0]  ex_dest_q, ex_dest_d;
  logic [REG_W-1:0]  mem_dest_q, wb_dest_q;
  logic              hazard;
  logic              taken;

  hazard_detect u_hazard (
    .ex_ctrl_i (ex_ctrl_q),
    .ex_dest_i (ex_dest_q),
    .id_ctrl_i (id_ctrl),
    .id_rs_i   (id_rs),
    .id_rt_i   (id_rt),
    .hazard_o  (hazard)
  );

  // Branch outcome from the ALU flags of the instruction currently in EX.
  assign taken = (ex_ctrl_q[B_BEQ]  &  ex_zero)
               | (ex_ctrl_q[B_BNE]  & ~ex_zero)
               | (ex_ctrl_q[B_BGTZ] & ~ex_zero & ~ex_neg);

  // A taken branch squashes the stalled instruction anyway, so flush wins.
  assign flush = taken & ~rst;
  assign stall = hazard & ~taken & ~rst;

  always_comb begin
    ex_ctrl_d = id_ctrl;
    ex_dest_d = id_ctrl[B_REGDST] ? id_rd : id_rt;
    if (stall || flush) begin
      ex_ctrl_d = CTRL_BUBBLE;
      ex_dest_d = REG_W'(0);
    end
  end

  // EX/MEM and MEM/WB always advance; only ID/EX can take a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl_q  <= CTRL_BUBBLE;
      mem_ctrl_q <= CTRL_BUBBLE;
      wb_ctrl_q  <= CTRL_BUBBLE;
      ex_dest_q  <= REG_W'(0);
      mem_dest_q <= REG_W'(0);
      wb_dest_q  <= REG_W'(0);
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      mem_ctrl_q <= ex_ctrl_q;
      wb_ctrl_q  <= mem_ctrl_q;
      ex_dest_q  <= ex_dest_d;
      mem_dest_q <= ex_dest_q;
      wb_dest_q  <= mem_dest_q;
    end
  end

  assign ex_ctrl  = ex_ctrl_q;
  assign mem_ctrl = mem_ctrl_q;
  assign wb_ctrl  = wb_ctrl_q;
  assign ex_dest  = ex_dest_q;
  assign mem_dest = mem_dest_q;
  assign wb_dest  = wb_dest_q;

`ifdef CTRL_PIPE_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= CNT_W'(0);
      flush_cnt_q <= CNT_W'(0);
    end else begin
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = CNT_W'(0);
  assign flush_cnt = CNT_W'(0);
`endif

endmodule
